bitstream_unpacker: RTL and testbench

Upstream neighbour of the EBPC symbol decoder. It accepts packed compressed words from the input stream and holds them in a 2×DATA_W-bit shift buffer. It presents an MSB-aligned DATA_W-bit window plus a saturated fill count to the decoder. On each decoder handshake it discards exactly `len_i` bits, so variable-length symbols (2…DATA_W bits) can be consumed back-to-back at one symbol per cycle.

---
 rtl/bitstream_unpacker.sv | 99 +++++++++
 tb/tb_bitstream_unpacker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bitstream_unpacker.sv
// rtl/bitstream_unpacker.sv - Shift-buffer unpacker feeding MSB-aligned windows to the EBPC decoder.
// Optional sticky underflow flag enabled by EBPC_UNPACKER_ERR_EN.

package ebpc_pkg;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LOG_DATA_W = 3;
endpackage

module bitstream_unpacker
  import ebpc_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  vld_i,
  output logic                  rdy_o,
  output logic [DATA_W-1:0]     data_o,
  output logic [LOG_DATA_W:0]   fill_state_o,
  output logic                  vld_o,
  input  logic                  rdy_i,
  input  logic [LOG_DATA_W:0]   len_i,
  input  logic                  clr_i,
  output logic                  err_o
);

  localparam int unsigned BUF_W  = 2 * DATA_W;
  localparam int unsigned FILL_W = $clog2(BUF_W + 1);

  logic [BUF_W-1:0]  buf_q, buf_d, buf_shift, push_bits;
  logic [FILL_W-1:0] fill_q, fill_d, fill_c, len_ext, cons;
  logic              hs_in, hs_out;

  assign hs_in   = vld_i & rdy_o;
  assign hs_out  = vld_o & rdy_i;
  assign len_ext = FILL_W'(len_i);

  // Clamp the consume length so an underflow simply empties the buffer.
  assign cons      = !hs_out ? '0 : ((len_ext > fill_q) ? fill_q : len_ext);
  assign buf_shift = buf_q << cons;
  assign fill_c    = fill_q - cons;
  assign push_bits = {data_i, {DATA_W{1'b0}}} >> fill_c;

  always_comb begin
    buf_d  = buf_shift;
    fill_d = fill_c;
    if (hs_in) begin
      buf_d  = buf_shift | push_bits;
      fill_d = fill_c + FILL_W'(DATA_W);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else if (clr_i) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign rdy_o        = (fill_q <= FILL_W'(DATA_W));
  assign vld_o        = (fill_q != '0);
  assign data_o       = buf_q[BUF_W-1:DATA_W];
  assign fill_state_o = (fill_q >= FILL_W'(DATA_W)) ? (LOG_DATA_W+1)'(DATA_W)
                                                    : fill_q[LOG_DATA_W:0];

`ifdef EBPC_UNPACKER_ERR_EN
  logic underflow;
  logic err_q;

  assign underflow = hs_out & (len_ext > fill_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (clr_i) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clr_i && underflow)
      $warning("bitstream_unpacker: underflow len=%0d fill=%0d", len_i, fill_q);
  end
`endif

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_unpacker.sv
// tb/tb_bitstream_unpacker.sv - Directed self-checking bench for bitstream_unpacker (DATA_W = 8).

module tb_bitstream_unpacker;
  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] data_i;
  logic       vld_i;
  logic       rdy_o;
  logic [7:0] data_o;
  logic [3:0] fill_state_o;
  logic       vld_o;
  logic       rdy_i;
  logic [3:0] len_i;
  logic       clr_i;
  logic       err_o;

  int total = 0;
  int bad   = 0;
  logic exp_err;

  always #5 clk_i = ~clk_i;

  bitstream_unpacker dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_i       (data_i),
    .vld_i        (vld_i),
    .rdy_o        (rdy_o),
    .data_o       (data_o),
    .fill_state_o (fill_state_o),
    .vld_o        (vld_o),
    .rdy_i        (rdy_i),
    .len_i        (len_i),
    .clr_i        (clr_i),
    .err_o        (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then idle the inputs 1 time unit after the edge.
  task automatic step(input logic push, input logic [7:0] d, input logic cons,
                      input logic [3:0] len, input logic clr);
    vld_i  = push;
    data_i = d;
    rdy_i  = cons;
    len_i  = len;
    clr_i  = clr;
    @(posedge clk_i);
    #1;
    vld_i  = 1'b0;
    data_i = 8'h00;
    rdy_i  = 1'b0;
    len_i  = 4'd0;
    clr_i  = 1'b0;
  endtask

  initial begin
`ifdef EBPC_UNPACKER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst_ni = 1'b0;
    vld_i = 1'b0; data_i = 8'h00; rdy_i = 1'b0; len_i = 4'd0; clr_i = 1'b0;
    #12;
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_fill", 32'(fill_state_o), 32'd0);
    chk("rst_vld", 32'(vld_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_rdy", 32'(rdy_o), 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    step(1'b1, 8'hA5, 1'b0, 4'd0, 1'b0);
    chk("push1_data", 32'(data_o), 32'hA5);
    chk("push1_fill", 32'(fill_state_o), 32'd8);
    chk("push1_vld", 32'(vld_o), 32'd1);
    chk("push1_rdy", 32'(rdy_o), 32'd1);

    step(1'b1, 8'h3C, 1'b0, 4'd0, 1'b0);
    chk("push2_fillq", 32'(dut.fill_q), 32'd16);
    chk("push2_fill", 32'(fill_state_o), 32'd8);
    chk("push2_rdy", 32'(rdy_o), 32'd0);
    chk("push2_data", 32'(data_o), 32'hA5);

    step(1'b0, 8'h00, 1'b1, 4'd3, 1'b0);
    chk("cons3_data", 32'(data_o), 32'h29);
    chk("cons3_fillq", 32'(dut.fill_q), 32'd13);
    chk("cons3_rdy", 32'(rdy_o), 32'd0);

    step(1'b0, 8'h00, 1'b1, 4'd5, 1'b0);
    chk("cons5_data", 32'(data_o), 32'h3C);
    chk("cons5_fillq", 32'(dut.fill_q), 32'd8);
    chk("cons5_rdy", 32'(rdy_o), 32'd1);

    step(1'b1, 8'hFF, 1'b1, 4'd2, 1'b0);
    chk("simul_data", 32'(data_o), 32'hF3);
    chk("simul_fillq", 32'(dut.fill_q), 32'd14);
    chk("simul_fill", 32'(fill_state_o), 32'd8);
    chk("simul_rdy", 32'(rdy_o), 32'd0);

    step(1'b0, 8'h00, 1'b1, 4'd8, 1'b0);
    chk("cons8_data", 32'(data_o), 32'hFC);
    chk("cons8_fill", 32'(fill_state_o), 32'd6);
    step(1'b0, 8'h00, 1'b1, 4'd2, 1'b0);
    chk("fill4_data", 32'(data_o), 32'hF0);
    chk("fill4_fill", 32'(fill_state_o), 32'd4);

    step(1'b0, 8'h00, 1'b1, 4'd6, 1'b0);
    chk("under_fillq", 32'(dut.fill_q), 32'd0);
    chk("under_vld", 32'(vld_o), 32'd0);
    chk("under_data", 32'(data_o), 32'h00);
    chk("under_err", 32'(err_o), 32'(exp_err));
    step(1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
    chk("under_err_hold", 32'(err_o), 32'(exp_err));

    step(1'b1, 8'hA5, 1'b0, 4'd0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 4'd0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 4'd3, 1'b0);
    chk("pre_clr_fillq", 32'(dut.fill_q), 32'd13);
    chk("pre_clr_err", 32'(err_o), 32'(exp_err));
    step(1'b1, 8'h77, 1'b1, 4'd2, 1'b1);
    chk("clr_fillq", 32'(dut.fill_q), 32'd0);
    chk("clr_data", 32'(data_o), 32'h00);
    chk("clr_rdy", 32'(rdy_o), 32'd1);
    chk("clr_err", 32'(err_o), 32'd0);
    chk("clr_vld", 32'(vld_o), 32'd0);

    step(1'b1, 8'hA5, 1'b0, 4'd0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 4'd0, 1'b0);
    chk("len0_data", 32'(data_o), 32'hA5);
    chk("len0_fill", 32'(fill_state_o), 32'd8);

    step(1'b1, 8'h3C, 1'b0, 4'd0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 4'd5, 1'b0);
    chk("mid_fillq", 32'(dut.fill_q), 32'd11);
    chk("mid_data", 32'(data_o), 32'hA7);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_data", 32'(data_o), 32'h00);
    chk("arst_fill", 32'(fill_state_o), 32'd0);
    chk("arst_vld", 32'(vld_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_rdy", 32'(rdy_o), 32'd1);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    step(1'b1, 8'h5A, 1'b0, 4'd0, 1'b0);
    chk("post_rst_data", 32'(data_o), 32'h5A);
    chk("post_rst_fill", 32'(fill_state_o), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
